// File: rtl/ddr_seq_pkg.sv
// Shared types and command encodings for the bank command sequencer and its open-row table.
package ddr_seq_pkg;

  localparam int ROW_W   = 14;
  localparam int COL_W   = 10;
  localparam int NBANK   = 8;
  localparam int BANK_SZ = 3;
  localparam int CMD_SZ  = 3;

  localparam logic [CMD_SZ-1:0] DDR_NOP     = 3'd0;
  localparam logic [CMD_SZ-1:0] DDR_ACT     = 3'd1;
  localparam logic [CMD_SZ-1:0] DDR_READ    = 3'd2;
  localparam logic [CMD_SZ-1:0] DDR_WRITE   = 3'd3;
  localparam logic [CMD_SZ-1:0] DDR_PRE     = 3'd4;
  localparam logic [CMD_SZ-1:0] DDR_PRE_ALL = 3'd5;
  localparam logic [CMD_SZ-1:0] DDR_REF     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECIDE = 3'd1,
    S_PRE    = 3'd2,
    S_ACT    = 3'd3,
    S_RW     = 3'd4,
    S_PREA   = 3'd5,
    S_REF    = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
  } open_row_t;

endpackage

// File: rtl/bank_cmd_sequencer_open_row_table.sv
// Per-bank open-row tracker: combinational lookup, registered set / clear-one / clear-all.
module open_row_table
  import ddr_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BANK_SZ-1:0] lk_bank_i,
  input  logic [ROW_W-1:0]   lk_row_i,
  output logic               lk_open_o,
  output logic               lk_hit_o,
  input  logic               set_i,
  input  logic [BANK_SZ-1:0] set_bank_i,
  input  logic [ROW_W-1:0]   set_row_i,
  input  logic               clr_i,
  input  logic [BANK_SZ-1:0] clr_bank_i,
  input  logic               clr_all_i
);

  open_row_t tbl_q [NBANK];
  open_row_t tbl_d [NBANK];

  always_comb begin
    tbl_d = tbl_q;
    if (clr_i) tbl_d[clr_bank_i].valid = 1'b0;
    if (set_i) tbl_d[set_bank_i] = {1'b1, set_row_i};
    // clear-all is applied last so it overrides a same-cycle set
    if (clr_all_i) begin
      for (int i = 0; i < NBANK; i++) tbl_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANK; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign lk_open_o = tbl_q[lk_bank_i].valid;
  assign lk_hit_o  = tbl_q[lk_bank_i].valid && (tbl_q[lk_bank_i].row == lk_row_i);

endmodule

// File: rtl/bank_cmd_sequencer.sv
// Expands one memory request at a time into PRE/ACT/RD/WR, plus PRE_ALL/REF for refresh,
// issuing each command only in a cycle where the timer says it is legal and the PHY is ready.
module bank_cmd_sequencer
  import ddr_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [BANK_SZ-1:0] req_bank,
  input  logic [ROW_W-1:0]   req_row,
  input  logic [COL_W-1:0]   req_col,
  input  logic               ref_req,
  output logic               ref_ack,
  output logic [CMD_SZ-1:0]  tmr_cmd,
  output logic [BANK_SZ-1:0] tmr_bank,
  input  logic               tmr_valid,
  input  logic [1:0]         tmr_offset,
  output logic               tmr_issue,
  output logic [1:0]         tmr_new_offset,
  input  logic               phy_ready,
  output logic               phy_cmd_valid,
  output logic [CMD_SZ-1:0]  phy_cmd,
  output logic [BANK_SZ-1:0] phy_bank,
  output logic [ROW_W-1:0]   phy_addr,
  output logic [1:0]         phy_slot,
  output logic [2:0]         dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
  // req_ready never depends on req_valid. A command issues in a cycle where tmr_valid & phy_ready.

  seq_state_t         state_q, state_d;
  logic               live_q;
  logic               lat_write_q;
  logic [BANK_SZ-1:0] lat_bank_q;
  logic [ROW_W-1:0]   lat_row_q;
  logic [COL_W-1:0]   lat_col_q;

  logic               go, issuing, accept;
  logic [ROW_W-1:0]   cmd_addr;
  logic               tbl_open, tbl_hit, tbl_set, tbl_clr, tbl_clr_all;

  assign go = tmr_valid & phy_ready;

  open_row_table u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_bank_i  (lat_bank_q),
    .lk_row_i   (lat_row_q),
    .lk_open_o  (tbl_open),
    .lk_hit_o   (tbl_hit),
    .set_i      (tbl_set),
    .set_bank_i (lat_bank_q),
    .set_row_i  (lat_row_q),
    .clr_i      (tbl_clr),
    .clr_bank_i (lat_bank_q),
    .clr_all_i  (tbl_clr_all)
  );

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    accept      = 1'b0;
    issuing     = 1'b0;
    tmr_cmd     = DDR_NOP;
    tmr_bank    = '0;
    cmd_addr    = '0;
    tbl_set     = 1'b0;
    tbl_clr     = 1'b0;
    tbl_clr_all = 1'b0;
    ref_ack     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // live_q keeps req_ready low until the first edge after reset release
        if (live_q) begin
          if (ref_req) begin
            state_d = S_PREA;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              accept  = 1'b1;
              state_d = S_DECIDE;
            end
          end
        end
      end
      S_DECIDE: begin
        if (tbl_hit)       state_d = S_RW;
        else if (tbl_open) state_d = S_PRE;
        else               state_d = S_ACT;
      end
      S_PRE: begin
        issuing  = 1'b1;
        tmr_cmd  = DDR_PRE;
        tmr_bank = lat_bank_q;
        if (go) begin
          tbl_clr = 1'b1;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        issuing  = 1'b1;
        tmr_cmd  = DDR_ACT;
        tmr_bank = lat_bank_q;
        cmd_addr = lat_row_q;
        if (go) begin
          tbl_set = 1'b1;
          state_d = S_RW;
        end
      end
      S_RW: begin
        issuing  = 1'b1;
        tmr_cmd  = lat_write_q ? DDR_WRITE : DDR_READ;
        tmr_bank = lat_bank_q;
        cmd_addr = {{(ROW_W-COL_W){1'b0}}, lat_col_q};
        if (go) state_d = S_IDLE;
      end
      S_PREA: begin
        issuing = 1'b1;
        tmr_cmd = DDR_PRE_ALL;
        if (go) begin
          tbl_clr_all = 1'b1;
          state_d     = S_REF;
        end
      end
      S_REF: begin
        issuing = 1'b1;
        tmr_cmd = DDR_REF;
        if (go) begin
          ref_ack = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmr_issue      = issuing & go;
  assign phy_cmd_valid  = issuing & go;
  assign phy_cmd        = (issuing & go) ? tmr_cmd    : DDR_NOP;
  assign phy_bank       = (issuing & go) ? tmr_bank   : '0;
  assign phy_addr       = (issuing & go) ? cmd_addr   : '0;
  assign phy_slot       = (issuing & go) ? tmr_offset : 2'b00;
  assign tmr_new_offset = (issuing & go) ? tmr_offset : 2'b00;
  assign dbg_state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      lat_write_q <= 1'b0;
      lat_bank_q  <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        lat_write_q <= req_write;
        lat_bank_q  <= req_bank;
        lat_row_q   <= req_row;
        lat_col_q   <= req_col;
      end
    end
  end

endmodule
